pc_sequencer: RTL and testbench

- Next-PC controller for the 5-bit fetch stage. Drives the PC register's input every cycle.
- Arbitrates between sequential increment, branch redirect, jump redirect, trap vector and pipeline stall.
- Issues one-cycle flush pulses to the IF/ID stages on redirect.
- Replaces free-running PC update with a sequenced, resettable FSM.

---
 rtl/pc_sequencer_if.sv | 14 +
 rtl/pc_sequencer.sv | 67 ++++++
 tb/tb_pc_sequencer.sv | 97 +++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: fetch-control bundle between hazard/decode logic and the next-PC sequencer
interface pc_sequencer_if #(parameter int PC_W = 5);
  logic stall, br_taken, jmp, trap_req;
  logic [PC_W-1:0] br_target, jmp_target, pc_out;
  logic pc_valid, flush_if, flush_id, trap_ack, stall_timeout;
  modport master(
    output stall, br_taken, br_target, jmp, jmp_target, trap_req,
    input pc_out, pc_valid, flush_if, flush_id, trap_ack, stall_timeout
  );
  modport slave(
    input stall, br_taken, br_target, jmp, jmp_target, trap_req,
    output pc_out, pc_valid, flush_if, flush_id, trap_ack, stall_timeout
  );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC FSM arbitrating trap/jump/branch/stall/increment; PC_TRACE_EN enables a negedge PC trace
module pc_sequencer #(
  parameter int PC_W = 5,
  parameter int RESET_PC = 21,
  parameter int TRAP_PC = 0,
  parameter int STALL_MAX = 15
) (
  input logic clk,
  input logic rst_n,
  pc_sequencer_if.slave bus
);
  localparam int CW = $clog2(STALL_MAX + 1);
  typedef enum logic [1:0] {BOOT, RUN, HOLD, REDIRECT} state_t;
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [PC_W-1:0] pc_nxt;
  logic flush_if_nxt, flush_id_nxt, ack_nxt, timeout_nxt;
  logic live, steer, do_trap, do_jmp, do_br, do_stall;
  // jmp/br come from flushed slots while in REDIRECT, so only RUN/HOLD may steer on them
  assign live = state != BOOT;
  assign steer = state == RUN || state == HOLD;
  assign do_trap = live && bus.trap_req;
  assign do_jmp = steer && bus.jmp && !bus.trap_req;
  assign do_br = steer && bus.br_taken && !bus.jmp && !bus.trap_req;
  assign do_stall = live && bus.stall && !do_trap && !do_jmp && !do_br;
  // state register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
      cnt <= '0;
      bus.pc_out <= PC_W'(RESET_PC);
      bus.pc_valid <= 1'b0;
      bus.flush_if <= 1'b0;
      bus.flush_id <= 1'b0;
      bus.trap_ack <= 1'b0;
      bus.stall_timeout <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
      bus.pc_out <= pc_nxt;
      bus.pc_valid <= 1'b1;
      bus.flush_if <= flush_if_nxt;
      bus.flush_id <= flush_id_nxt;
      bus.trap_ack <= ack_nxt;
      bus.stall_timeout <= timeout_nxt;
    end
  end
  // next state: BOOT always falls into RUN; redirects win over stall
  always_comb
    state_nxt = state == BOOT ? RUN : (do_trap || do_jmp || do_br) ? REDIRECT : do_stall ? HOLD : RUN;
  // next output values; stall count saturates and the timeout fires only on first reaching the limit
  always_comb begin
    pc_nxt = do_trap ? PC_W'(TRAP_PC) : do_jmp ? bus.jmp_target : do_br ? bus.br_target :
             (do_stall || !live) ? bus.pc_out : bus.pc_out + 1'b1;
    flush_if_nxt = do_trap || do_jmp || do_br;
    flush_id_nxt = do_trap || do_br;
    ack_nxt = do_trap;
    cnt_nxt = !do_stall ? '0 : cnt == CW'(STALL_MAX) ? cnt : cnt + 1'b1;
    timeout_nxt = do_stall && cnt_nxt == CW'(STALL_MAX) && cnt != CW'(STALL_MAX);
  end
`ifdef PC_TRACE_EN
  // simulation-only fetch trace
  always @(negedge clk)
    if (bus.pc_valid)
      $display("PC = %d%s", bus.pc_out, state == REDIRECT ? " (REDIRECT)" : state == HOLD ? " (STALL)" : "");
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed plan plus random traffic against a behavioural next-PC model
module tb_pc_sequencer;
  localparam int RESET_PC = 21, TRAP_PC = 0, STALL_MAX = 15;
  logic clk = 0, rst_n = 0;
  int errors = 0, checks = 0;
  int m_pc, m_run;
  bit m_valid, m_boot, m_redir, e_fif, e_fid, e_ack, e_to;
  pc_sequencer_if #(.PC_W(5)) bus();
  pc_sequencer #(.PC_W(5), .RESET_PC(RESET_PC), .TRAP_PC(TRAP_PC), .STALL_MAX(STALL_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(string tag, int got, int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_pc = RESET_PC; m_valid = 0; m_boot = 1; m_redir = 0; m_run = 0;
    e_fif = 0; e_fid = 0; e_ack = 0; e_to = 0;
  endtask
  task automatic model_step(bit s, bit br, int bt, bit j, int jt, bit t);
    e_fif = 0; e_fid = 0; e_ack = 0; e_to = 0;
    if (m_boot) begin
      m_boot = 0; m_valid = 1;
    end else if (t) begin
      m_pc = TRAP_PC; e_ack = 1; e_fif = 1; e_fid = 1; m_redir = 1; m_run = 0;
    end else if (j && !m_redir) begin
      m_pc = jt; e_fif = 1; m_redir = 1; m_run = 0;
    end else if (br && !m_redir) begin
      m_pc = bt; e_fif = 1; e_fid = 1; m_redir = 1; m_run = 0;
    end else if (s) begin
      m_run++; e_to = m_run == STALL_MAX; m_redir = 0;
    end else begin
      m_pc = (m_pc + 1) % 32; m_redir = 0; m_run = 0;
    end
  endtask
  task automatic compare_all();
    check("pc_out", int'(bus.pc_out), m_pc);
    check("pc_valid", int'(bus.pc_valid), int'(m_valid));
    check("flush_if", int'(bus.flush_if), int'(e_fif));
    check("flush_id", int'(bus.flush_id), int'(e_fid));
    check("trap_ack", int'(bus.trap_ack), int'(e_ack));
    check("stall_timeout", int'(bus.stall_timeout), int'(e_to));
  endtask
  task automatic cyc(bit r, bit s, bit br, int bt, bit j, int jt, bit t);
    @(negedge clk);
    if (r) begin
      #1 rst_n = 0;
      model_reset();
      #1 compare_all();
      #1 rst_n = 1;
    end
    bus.stall = s; bus.br_taken = br; bus.br_target = 5'(bt);
    bus.jmp = j; bus.jmp_target = 5'(jt); bus.trap_req = t;
    model_step(s, br, bt, j, jt, t);
    @(posedge clk);
    #1 compare_all();
  endtask
  initial begin
    bus.stall = 0; bus.br_taken = 0; bus.br_target = 0;
    bus.jmp = 0; bus.jmp_target = 0; bus.trap_req = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (3) cyc(0, 0, 0, 0, 0, 0, 0);
    check("plan_seq", int'(bus.pc_out), 24);
    repeat (14) cyc(0, 1, 0, 0, 0, 0, 0);
    check("plan_no_early_timeout", int'(bus.stall_timeout), 0);
    cyc(0, 1, 0, 0, 0, 0, 0);
    check("plan_timeout_15", int'(bus.stall_timeout), 1);
    cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("plan_after_stall", int'(bus.pc_out), 25);
    cyc(0, 0, 0, 0, 1, 29, 0);
    repeat (4) cyc(0, 0, 0, 0, 0, 0, 0);
    check("plan_wrap", int'(bus.pc_out), 1);
    cyc(0, 0, 1, 7, 1, 12, 0);
    check("plan_jmp_wins", int'(bus.pc_out), 12);
    cyc(0, 0, 1, 7, 0, 0, 0);
    check("plan_br_in_redirect", int'(bus.pc_out), 13);
    cyc(0, 1, 1, 7, 0, 0, 1);
    check("plan_trap_ack", int'(bus.trap_ack), 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    check("plan_after_trap", int'(bus.pc_out), 1);
    repeat (5) cyc(0, 1, 0, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0);
    check("plan_reset_boot", int'(bus.pc_out), RESET_PC);
    repeat (16) cyc(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(199) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0, $urandom_range(31),
          $urandom_range(9) == 0, $urandom_range(31), $urandom_range(15) == 0);
    for (int i = 0; i < 40; i++) cyc(0, 1, 0, 0, 0, 0, i == 20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
